issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 110 +++++++++++
 tb/tb_issue_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// Decoded-instruction issue queue between ID and issue: DEPTH-entry circular FIFO of BUS_WD-bit entries.
// Latency: 1 cycle push -> iq_to_is_valid; 0 cycles when built with IQ_BYPASS_EN and the queue is empty.
// Backpressure: IQ_allowin drops when full or flushing; the head is held until is_allowin.
//
// Ports: clk / resetn (async, active-low) / flush (discard all entries)
//        ds_to_is_valid, ds_to_is_bus  -> entry offered by ID;  IQ_allowin -> ID may hand over an entry
//        is_allowin                    <- issue stage takes the head
//        iq_to_is_valid, iq_to_is_bus  -> head entry;  iq_count -> occupied entries
// Optional feature macro: IQ_BYPASS_EN (empty-queue same-cycle bypass ID -> issue).
module issue_queue #(
    parameter int BUS_WD = 175,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              ds_to_is_valid,
    input  logic [BUS_WD-1:0] ds_to_is_bus,
    output logic              IQ_allowin,
    input  logic              is_allowin,
    output logic              iq_to_is_valid,
    output logic [BUS_WD-1:0] iq_to_is_bus,
    output logic [$clog2(DEPTH):0] iq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    logic [BUS_WD-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    occ_t              occ;
    logic              bypass;
    logic              push;
    logic              pop;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == FULL_CNT) begin
            occ = OCC_FULL;
        end
    end

`ifdef IQ_BYPASS_EN
    // Empty queue and a ready consumer: the offered entry goes straight
    // through and never touches storage, pointers or the count.
    assign bypass         = (occ == OCC_EMPTY) && ds_to_is_valid && is_allowin && !flush;
    assign iq_to_is_valid = bypass || ((occ != OCC_EMPTY) && !flush);
    assign iq_to_is_bus   = bypass ? ds_to_is_bus : mem[rd_ptr];
`else
    assign bypass         = 1'b0;
    assign iq_to_is_valid = (occ != OCC_EMPTY) && !flush;
    assign iq_to_is_bus   = mem[rd_ptr];
`endif

    // Depends only on occupancy and flush, never on is_allowin, so a full
    // queue does not open a comb path from the issue stage back to ID.
    assign IQ_allowin = (occ != OCC_FULL) && !flush;
    assign push       = ds_to_is_valid && IQ_allowin && !bypass;
    // A bypass only happens when empty, so it can never coincide with a pop.
    assign pop        = (occ != OCC_EMPTY) && !flush && is_allowin;
    assign iq_count   = count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Stored entries are left in place; resetting the pointers and
            // count is enough to make them unreachable.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= ds_to_is_bus;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: reset, fill/drain, steady push+pop with
// pointer wrap, flush, bypass (or one-cycle latency) and mid-stream reset.
module tb_issue_queue;

    localparam int BW    = 175;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          resetn;
    logic          flush;
    logic          ds_to_is_valid;
    logic [BW-1:0] ds_to_is_bus;
    logic          IQ_allowin;
    logic          is_allowin;
    logic          iq_to_is_valid;
    logic [BW-1:0] iq_to_is_bus;
    logic [CW-1:0] iq_count;

    int checks = 0;
    int errors = 0;

    issue_queue #(.BUS_WD(BW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .ds_to_is_valid (ds_to_is_valid),
        .ds_to_is_bus   (ds_to_is_bus),
        .IQ_allowin     (IQ_allowin),
        .is_allowin     (is_allowin),
        .iq_to_is_valid (iq_to_is_valid),
        .iq_to_is_bus   (iq_to_is_bus),
        .iq_count       (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk(input logic [31:0] pc);
        mk = {47'h0, ~pc, 32'h0, pc, pc};
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then changed and
    // outputs sampled mid-cycle, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [BW-1:0] seq [5];
    int exp_cnt [5] = '{4, 3, 3, 2, 1};

    initial begin
        resetn = 1'b0; flush = 1'b0; ds_to_is_valid = 1'b0; ds_to_is_bus = '0; is_allowin = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_valid",   BW'(iq_to_is_valid), BW'(0));
        check("rst_count",   BW'(iq_count),       BW'(0));
        check("rst_allowin", BW'(IQ_allowin),     BW'(1));
        check("rst_bus",     iq_to_is_bus,        '0);
        tick();
        resetn = 1'b1;

        // Fill A..D with the issue stage stalled
        for (int i = 0; i < 4; i++) begin
            seq[i] = mk(32'h1c00_0000 + 32'(4 * i));
            ds_to_is_valid = 1'b1;
            ds_to_is_bus   = seq[i];
            #1;
            check("fill_allowin", BW'(IQ_allowin),     BW'(1));
            check("fill_count",   BW'(iq_count),       BW'(i));
            check("fill_valid",   BW'(iq_to_is_valid), BW'(i != 0));
            tick();
        end
        // Fifth offer (E) must be held while full
        seq[4] = mk(32'h1c00_0010);
        ds_to_is_bus = seq[4];
        #1;
        check("full_allowin", BW'(IQ_allowin), BW'(0));
        check("full_count",   BW'(iq_count),   BW'(4));
        tick();
        check("full_hold",    BW'(iq_count),   BW'(4));
        check("full_head",    iq_to_is_bus,    seq[0]);

        // Drain; E enters as soon as a slot frees
        is_allowin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("drain_valid", BW'(iq_to_is_valid), BW'(1));
            check("drain_bus",   iq_to_is_bus,        seq[k]);
            check("drain_count", BW'(iq_count),       BW'(exp_cnt[k]));
            tick();
            if (k == 1) ds_to_is_valid = 1'b0;
        end
        check("drain_empty_valid", BW'(iq_to_is_valid), BW'(0));
        check("drain_empty_count", BW'(iq_count),       BW'(0));

        // Steady push+pop at count 2 for 8 cycles; pointers wrap
        is_allowin = 1'b0;
        ds_to_is_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ds_to_is_bus = mk(32'h1c00_0100 + 32'(4 * i));
            tick();
        end
        is_allowin = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ds_to_is_bus = mk(32'h1c00_0100 + 32'(4 * (k + 2)));
            #1;
            check("pp_count", BW'(iq_count),  BW'(2));
            check("pp_bus",   iq_to_is_bus,   mk(32'h1c00_0100 + 32'(4 * k)));
            tick();
        end
        ds_to_is_valid = 1'b0;
        for (int k = 8; k < 10; k++) begin
            #1;
            check("pp_tail", iq_to_is_bus, mk(32'h1c00_0100 + 32'(4 * k)));
            tick();
        end
        check("pp_done", BW'(iq_count), BW'(0));

        // Flush with three entries and a concurrent offer
        is_allowin = 1'b0;
        ds_to_is_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ds_to_is_bus = mk(32'h1c00_0200 + 32'(4 * i));
            tick();
        end
        check("pre_flush_count", BW'(iq_count), BW'(3));
        flush = 1'b1;
        is_allowin = 1'b1;
        ds_to_is_bus = mk(32'h1c00_02f0);
        #1;
        check("flush_valid",   BW'(iq_to_is_valid), BW'(0));
        check("flush_allowin", BW'(IQ_allowin),     BW'(0));
        tick();
        flush = 1'b0;
        ds_to_is_valid = 1'b0;
        #1;
        check("post_flush_count", BW'(iq_count),       BW'(0));
        check("post_flush_valid", BW'(iq_to_is_valid), BW'(0));
        is_allowin = 1'b0;
        ds_to_is_valid = 1'b1;
        ds_to_is_bus = mk(32'h1c00_0300);
        tick();
        ds_to_is_valid = 1'b0;
        check("post_flush_push_cnt", BW'(iq_count), BW'(1));
        check("post_flush_push_bus", iq_to_is_bus,  mk(32'h1c00_0300));
        is_allowin = 1'b1;
        tick();
        check("post_flush_drained", BW'(iq_count), BW'(0));

        // Empty queue, consumer ready, offer E
        ds_to_is_valid = 1'b1;
        ds_to_is_bus = mk(32'h1c00_0400);
        #1;
`ifdef IQ_BYPASS_EN
        check("byp_valid", BW'(iq_to_is_valid), BW'(1));
        check("byp_bus",   iq_to_is_bus,        mk(32'h1c00_0400));
        check("byp_count", BW'(iq_count),       BW'(0));
        tick();
        ds_to_is_valid = 1'b0;
        #1;
        check("byp_after_count", BW'(iq_count),       BW'(0));
        check("byp_after_valid", BW'(iq_to_is_valid), BW'(0));
`else
        check("lat_same_valid", BW'(iq_to_is_valid), BW'(0));
        check("lat_same_count", BW'(iq_count),       BW'(0));
        tick();
        ds_to_is_valid = 1'b0;
        #1;
        check("lat_next_valid", BW'(iq_to_is_valid), BW'(1));
        check("lat_next_bus",   iq_to_is_bus,        mk(32'h1c00_0400));
        check("lat_next_count", BW'(iq_count),       BW'(1));
        tick();
        check("lat_drained", BW'(iq_count), BW'(0));
`endif

        // Mid-stream asynchronous reset
        is_allowin = 1'b0;
        ds_to_is_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ds_to_is_bus = mk(32'h1c00_0500 + 32'(4 * i));
            tick();
        end
        ds_to_is_valid = 1'b0;
        check("pre_rst_count", BW'(iq_count), BW'(2));
        resetn = 1'b0;
        #1;
        check("mid_rst_count",   BW'(iq_count),       BW'(0));
        check("mid_rst_valid",   BW'(iq_to_is_valid), BW'(0));
        check("mid_rst_allowin", BW'(IQ_allowin),     BW'(1));
        check("mid_rst_bus",     iq_to_is_bus,        '0);
        tick();
        resetn = 1'b1;
        ds_to_is_valid = 1'b1;
        ds_to_is_bus = mk(32'h1c00_0600);
        tick();
        ds_to_is_valid = 1'b0;
        check("rel_count", BW'(iq_count), BW'(1));
        check("rel_bus",   iq_to_is_bus,  mk(32'h1c00_0600));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
